// File: rtl/bp_cce_mem_stream_mux_pkg.sv
// Shared types and widths for the multi-slice CCE memory stream mux.
// The header struct stands in for the BedRock mem header of the default config.
package bp_cce_mem_stream_mux_pkg;

  localparam int paddr_width_gp        = 40;
  localparam int did_width_gp          = 3;
  localparam int lce_id_width_gp       = 4;
  localparam int lce_assoc_gp          = 8;
  localparam int bedrock_data_width_gp = 64;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int way_width_gp = safe_clog2(lce_assoc_gp);

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    bp_bedrock_mem_type_e        msg_type;
    logic [3:0]                  subop;
    logic [paddr_width_gp-1:0]   addr;
    logic [2:0]                  size;
    logic [did_width_gp-1:0]     did;
    logic [lce_id_width_gp-1:0]  lce_id;
    logic [way_width_gp-1:0]     way_id;
  } bp_bedrock_mem_header_s;

  localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic {
    e_arb_idle,
    e_arb_locked
  } arb_state_e;

endpackage

// File: rtl/bp_cce_mem_stream_mux_arb.sv
// Round-robin stream arbiter that holds its grant until the last beat.
// New grants are only issued while grant_en_i is high.
module bp_cce_mem_stream_mux_arb
  import bp_cce_mem_stream_mux_pkg::*;
#(
  parameter  int num_p = 2,
  localparam int id_w  = safe_clog2(num_p)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [num_p-1:0] v_i,
  input  logic [num_p-1:0] last_i,
  input  logic             grant_en_i,
  input  logic             ready_i,
  output logic             grant_v_o,
  output logic [id_w-1:0]  grant_id_o,
  output logic             first_fire_o
);

  arb_state_e      r_state;
  arb_state_e      w_state_n;
  logic [id_w-1:0] r_rr;
  logic [id_w-1:0] w_rr_n;
  logic [id_w-1:0] r_lock;
  logic [id_w-1:0] w_lock_n;
  logic [id_w-1:0] w_rr_id;
  logic            w_rr_v;
  logic            w_fire;

  // Walk downward so the channel closest to the pointer wins.
  always_comb begin
    w_rr_v  = 1'b0;
    w_rr_id = '0;
    for (int i = num_p - 1; i >= 0; i--) begin
      if (v_i[id_w'((int'(r_rr) + i) % num_p)]) begin
        w_rr_v  = 1'b1;
        w_rr_id = id_w'((int'(r_rr) + i) % num_p);
      end
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_rr_n       = r_rr;
    w_lock_n     = r_lock;
    w_fire       = 1'b0;
    grant_v_o    = 1'b0;
    grant_id_o   = w_rr_id;
    first_fire_o = 1'b0;
    unique case (r_state)
      e_arb_idle: begin
        grant_v_o = w_rr_v & grant_en_i;
        w_fire    = w_rr_v & grant_en_i & ready_i;
        if (w_fire) begin
          first_fire_o = 1'b1;
          w_rr_n = id_w'((int'(w_rr_id) + 1) % num_p);
          if (!last_i[w_rr_id]) begin
            w_state_n = e_arb_locked;
            w_lock_n  = w_rr_id;
          end
        end
      end
      e_arb_locked: begin
        grant_v_o  = 1'b1;
        grant_id_o = r_lock;
        w_fire     = v_i[r_lock] & ready_i;
        if (w_fire & last_i[r_lock]) begin
          w_state_n = e_arb_idle;
        end
      end
      default: w_state_n = e_arb_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_arb_idle;
      r_rr    <= '0;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_n;
      r_rr    <= w_rr_n;
      r_lock  <= w_lock_n;
    end
  end

endmodule

// File: rtl/bp_cce_mem_stream_mux.sv
// Merges per-slice CCE mem_cmd streams onto one port and steers in-order
// mem_resp streams back. Optional stall counter: BP_CCE_MEM_MUX_STALL_CNT_EN.
module bp_cce_mem_stream_mux
  import bp_cce_mem_stream_mux_pkg::*;
#(
  parameter  int num_cce_p         = 2,
  parameter  int max_outstanding_p = 4,
  localparam int hdr_w             = mem_header_width_gp,
  localparam int data_w            = bedrock_data_width_gp,
  localparam int ch_id_width_lp    = safe_clog2(num_cce_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [num_cce_p*hdr_w-1:0]    mem_cmd_header_i,
  input  logic [num_cce_p*data_w-1:0]   mem_cmd_data_i,
  input  logic [num_cce_p-1:0]          mem_cmd_v_i,
  output logic [num_cce_p-1:0]          mem_cmd_ready_and_o,
  input  logic [num_cce_p-1:0]          mem_cmd_last_i,
  output logic [hdr_w-1:0]              mem_cmd_header_o,
  output logic [data_w-1:0]             mem_cmd_data_o,
  output logic                          mem_cmd_v_o,
  input  logic                          mem_cmd_ready_and_i,
  output logic                          mem_cmd_last_o,
  input  logic [hdr_w-1:0]              mem_resp_header_i,
  input  logic [data_w-1:0]             mem_resp_data_i,
  input  logic                          mem_resp_v_i,
  output logic                          mem_resp_ready_and_o,
  input  logic                          mem_resp_last_i,
  output logic [num_cce_p*hdr_w-1:0]    mem_resp_header_o,
  output logic [num_cce_p*data_w-1:0]   mem_resp_data_o,
  output logic [num_cce_p-1:0]          mem_resp_v_o,
  input  logic [num_cce_p-1:0]          mem_resp_ready_and_i,
  output logic [num_cce_p-1:0]          mem_resp_last_o,
  output logic [31:0]                   stall_count_o
);

  localparam int ptr_w = safe_clog2(max_outstanding_p);
  localparam int cnt_w = $clog2(max_outstanding_p + 1);

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(max_outstanding_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  logic                                r_hold;
  logic                                w_gate;
  logic [num_cce_p-1:0][hdr_w-1:0]     w_hdr_arr;
  logic [num_cce_p-1:0][data_w-1:0]    w_data_arr;
  logic                                w_grant_v;
  logic [ch_id_width_lp-1:0]           w_grant_id;
  logic                                w_first_fire;
  logic [ch_id_width_lp-1:0]           r_ids [max_outstanding_p];
  logic [ptr_w-1:0]                    r_wptr;
  logic [ptr_w-1:0]                    r_rptr;
  logic [cnt_w-1:0]                    r_count;
  logic                                w_full;
  logic                                w_empty;
  logic                                w_push;
  logic                                w_pop;
  logic [ch_id_width_lp-1:0]           w_dest;

  // Outputs stay quiet through reset and the first cycle after it.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_hold <= 1'b1;
    else         r_hold <= 1'b0;
  end

  assign w_gate  = reset_i | r_hold;
  assign w_full  = (r_count == cnt_w'(max_outstanding_p));
  assign w_empty = (r_count == '0);

  bp_cce_mem_stream_mux_arb #(
    .num_p(num_cce_p)
  ) u_arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (mem_cmd_v_i),
    .last_i      (mem_cmd_last_i),
    .grant_en_i  (~w_full & ~w_gate),
    .ready_i     (mem_cmd_ready_and_i & ~w_gate),
    .grant_v_o   (w_grant_v),
    .grant_id_o  (w_grant_id),
    .first_fire_o(w_first_fire)
  );

  assign w_hdr_arr        = mem_cmd_header_i;
  assign w_data_arr       = mem_cmd_data_i;
  assign mem_cmd_header_o = w_hdr_arr[w_grant_id];
  assign mem_cmd_data_o   = w_data_arr[w_grant_id];
  assign mem_cmd_last_o   = mem_cmd_last_i[w_grant_id];
  assign mem_cmd_v_o      = w_grant_v & ~w_gate & mem_cmd_v_i[w_grant_id];

  always_comb begin
    mem_cmd_ready_and_o = '0;
    if (w_grant_v & ~w_gate) begin
      mem_cmd_ready_and_o[w_grant_id] = mem_cmd_ready_and_i;
    end
  end

  assign w_push = w_first_fire;
  assign w_pop  = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

  always_ff @(posedge clk_i) begin
    if (w_push) r_ids[r_wptr] <= w_grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_w'(1);
        2'b01:   r_count <= r_count - cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_dest = r_ids[r_rptr];

  always_comb begin
    mem_resp_v_o = '0;
    if (~w_empty & ~w_gate) begin
      mem_resp_v_o[w_dest] = mem_resp_v_i;
    end
  end

  assign mem_resp_ready_and_o =
    mem_resp_ready_and_i[w_dest] & ~w_empty & ~w_gate;
  assign mem_resp_header_o = {num_cce_p{mem_resp_header_i}};
  assign mem_resp_data_o   = {num_cce_p{mem_resp_data_i}};
  assign mem_resp_last_o   = {num_cce_p{mem_resp_last_i}};

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(mem_resp_v_i && w_empty))
        else $error("mem_resp beat arrived with no outstanding command");
    end
  end

`ifdef BP_CCE_MEM_MUX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_stall_cnt <= '0;
    end else if (mem_cmd_v_o & ~mem_cmd_ready_and_i & ~&r_stall_cnt) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_count_o = r_stall_cnt;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_bp_cce_mem_stream_mux.sv
// Self-checking bench for bp_cce_mem_stream_mux with two CCE channels.
// Vector table for arbitration, scripted sequences for multi-cycle cases.
module tb_bp_cce_mem_stream_mux;
  import bp_cce_mem_stream_mux_pkg::*;

  localparam int N  = 2;
  localparam int HW = mem_header_width_gp;
  localparam int DW = bedrock_data_width_gp;
`ifdef BP_CCE_MEM_MUX_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd10;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [N*HW-1:0] mem_cmd_header_i;
  logic [N*DW-1:0] mem_cmd_data_i;
  logic [N-1:0]    mem_cmd_v_i;
  logic [N-1:0]    mem_cmd_ready_and_o;
  logic [N-1:0]    mem_cmd_last_i;
  logic [HW-1:0]   mem_cmd_header_o;
  logic [DW-1:0]   mem_cmd_data_o;
  logic            mem_cmd_v_o;
  logic            mem_cmd_ready_and_i;
  logic            mem_cmd_last_o;
  logic [HW-1:0]   mem_resp_header_i;
  logic [DW-1:0]   mem_resp_data_i;
  logic            mem_resp_v_i;
  logic            mem_resp_ready_and_o;
  logic            mem_resp_last_i;
  logic [N*HW-1:0] mem_resp_header_o;
  logic [N*DW-1:0] mem_resp_data_o;
  logic [N-1:0]    mem_resp_v_o;
  logic [N-1:0]    mem_resp_ready_and_i;
  logic [N-1:0]    mem_resp_last_o;
  logic [31:0]     stall_count_o;

  bp_cce_mem_stream_mux #(
    .num_cce_p(N),
    .max_outstanding_p(4)
  ) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .mem_cmd_header_i    (mem_cmd_header_i),
    .mem_cmd_data_i      (mem_cmd_data_i),
    .mem_cmd_v_i         (mem_cmd_v_i),
    .mem_cmd_ready_and_o (mem_cmd_ready_and_o),
    .mem_cmd_last_i      (mem_cmd_last_i),
    .mem_cmd_header_o    (mem_cmd_header_o),
    .mem_cmd_data_o      (mem_cmd_data_o),
    .mem_cmd_v_o         (mem_cmd_v_o),
    .mem_cmd_ready_and_i (mem_cmd_ready_and_i),
    .mem_cmd_last_o      (mem_cmd_last_o),
    .mem_resp_header_i   (mem_resp_header_i),
    .mem_resp_data_i     (mem_resp_data_i),
    .mem_resp_v_i        (mem_resp_v_i),
    .mem_resp_ready_and_o(mem_resp_ready_and_o),
    .mem_resp_last_i     (mem_resp_last_i),
    .mem_resp_header_o   (mem_resp_header_o),
    .mem_resp_data_o     (mem_resp_data_o),
    .mem_resp_v_o        (mem_resp_v_o),
    .mem_resp_ready_and_i(mem_resp_ready_and_i),
    .mem_resp_last_o     (mem_resp_last_o),
    .stall_count_o       (stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] v;
    logic [1:0] last;
    logic       rdy;
    logic       exp_v;
    logic [1:0] exp_rdy;
    int         exp_ch;
  } cmd_vec_t;

  cmd_vec_t   tbl [6];
  int         exp_q[$];
  logic [DW-1:0] rx_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [HW-1:0] hdr_of(input int ch, input int b);
    logic [63:0] t;
    t = 64'h0AB0_0000 + 64'(ch * 256 + b);
    return t[HW-1:0];
  endfunction

  function automatic logic [DW-1:0] dat_of(input int ch, input int b);
    return 64'hDA7A_0000_0000_0000 + 64'(ch * 256 + b);
  endfunction

  function automatic logic [DW-1:0] rsp_of(input int b);
    return 64'h5E50_0000_0000_0000 + 64'(b);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic [1:0] v, input logic [1:0] last,
                           input logic rdy, input int b0, input int b1);
    mem_cmd_v_i         = v;
    mem_cmd_last_i      = last;
    mem_cmd_ready_and_i = rdy;
    mem_cmd_header_i    = {hdr_of(1, b1), hdr_of(0, b0)};
    mem_cmd_data_i      = {dat_of(1, b1), dat_of(0, b0)};
  endtask

  task automatic drive_resp(input logic v, input logic last,
                            input logic [1:0] rdy, input int b);
    mem_resp_v_i         = v;
    mem_resp_last_i      = last;
    mem_resp_ready_and_i = rdy;
    mem_resp_header_i    = hdr_of(3, b);
    mem_resp_data_i      = rsp_of(b);
  endtask

  // Single-beat responses, each routed to the oldest outstanding channel.
  task automatic drain(input int n);
    int d;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      drive_cmd(2'b00, 2'b00, 1'b1, 0, 0);
      drive_resp(1'b1, 1'b1, 2'b11, 16 + k);
      #2;
      if (exp_q.size() == 0) begin
        chk("drain_q_empty", 1, 0);
      end else begin
        d = exp_q.pop_front();
        chk("resp_dst", mem_resp_v_o, 128'(2'b01 << d));
        chk("resp_rdy", mem_resp_ready_and_o, 1);
        chk("resp_hdr", mem_resp_header_o, {hdr_of(3, 16 + k), hdr_of(3, 16 + k)});
        chk("resp_last", mem_resp_last_o, 2'b11);
      end
    end
    @(negedge clk_i);
    drive_resp(1'b0, 1'b0, 2'b11, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t required below 200000", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] pat;
    int b;

    tbl[0] = '{v: 2'b11, last: 2'b11, rdy: 1'b1, exp_v: 1'b1, exp_rdy: 2'b01, exp_ch: 0};
    tbl[1] = '{v: 2'b11, last: 2'b11, rdy: 1'b1, exp_v: 1'b1, exp_rdy: 2'b10, exp_ch: 1};
    tbl[2] = '{v: 2'b11, last: 2'b11, rdy: 1'b1, exp_v: 1'b1, exp_rdy: 2'b01, exp_ch: 0};
    tbl[3] = '{v: 2'b11, last: 2'b11, rdy: 1'b1, exp_v: 1'b1, exp_rdy: 2'b10, exp_ch: 1};
    tbl[4] = '{v: 2'b11, last: 2'b11, rdy: 1'b1, exp_v: 1'b0, exp_rdy: 2'b00, exp_ch: 0};
    tbl[5] = '{v: 2'b01, last: 2'b01, rdy: 1'b0, exp_v: 1'b0, exp_rdy: 2'b00, exp_ch: 0};

    reset_i = 1'b1;
    drive_cmd(2'b00, 2'b00, 1'b0, 0, 0);
    drive_resp(1'b0, 1'b0, 2'b00, 0);
    repeat (2) @(posedge clk_i);

    // Reset and the first cycle after it keep every valid/ready low.
    @(negedge clk_i);
    drive_cmd(2'b11, 2'b11, 1'b1, 0, 0);
    drive_resp(1'b0, 1'b0, 2'b11, 0);
    #2;
    chk("rst_cmd_v", mem_cmd_v_o, 0);
    chk("rst_cmd_rdy", mem_cmd_ready_and_o, 0);
    chk("rst_resp_v", mem_resp_v_o, 0);
    chk("rst_resp_rdy", mem_resp_ready_and_o, 0);
    chk("rst_stall", stall_count_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #2;
    chk("post_rst_cmd_v", mem_cmd_v_o, 0);
    chk("post_rst_cmd_rdy", mem_cmd_ready_and_o, 0);
    chk("post_rst_resp_rdy", mem_resp_ready_and_o, 0);

    // Alternating single-beat grants until the tracker fills.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      drive_cmd(tbl[i].v, tbl[i].last, tbl[i].rdy, i, i);
      #2;
      chk($sformatf("tbl%0d_v", i), mem_cmd_v_o, tbl[i].exp_v);
      chk($sformatf("tbl%0d_rdy", i), mem_cmd_ready_and_o, tbl[i].exp_rdy);
      if (tbl[i].exp_v) begin
        chk($sformatf("tbl%0d_hdr", i), mem_cmd_header_o, hdr_of(tbl[i].exp_ch, i));
        chk($sformatf("tbl%0d_dat", i), mem_cmd_data_o, dat_of(tbl[i].exp_ch, i));
        if (tbl[i].rdy) exp_q.push_back(tbl[i].exp_ch);
      end
    end

    // Fifth command blocked in the pop cycle, accepted the cycle after.
    @(negedge clk_i);
    drive_cmd(2'b01, 2'b01, 1'b1, 7, 7);
    drive_resp(1'b1, 1'b1, 2'b11, 0);
    #2;
    chk("full_pop_cmd_v", mem_cmd_v_o, 0);
    chk("full_pop_cmd_rdy", mem_cmd_ready_and_o, 0);
    chk("full_pop_resp_v", mem_resp_v_o, 128'(2'b01 << exp_q[0]));
    chk("full_pop_resp_rdy", mem_resp_ready_and_o, 1);
    void'(exp_q.pop_front());
    @(negedge clk_i);
    drive_resp(1'b0, 1'b0, 2'b11, 0);
    #2;
    chk("after_pop_cmd_v", mem_cmd_v_o, 1);
    chk("after_pop_cmd_rdy", mem_cmd_ready_and_o, 2'b01);
    chk("after_pop_hdr", mem_cmd_header_o, hdr_of(0, 7));
    exp_q.push_back(0);
    drain(4);

    // Multi-beat response to ch1 under consumer backpressure.
    @(negedge clk_i);
    drive_cmd(2'b10, 2'b10, 1'b1, 0, 9);
    #2;
    chk("c_cmd_rdy", mem_cmd_ready_and_o, 2'b10);
    exp_q.push_back(1);
    pat = 4'b1101;
    b = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      drive_cmd(2'b00, 2'b00, 1'b1, 0, 0);
      drive_resp(1'b1, b == 2, {pat[c], 1'b1}, b);
      #2;
      chk($sformatf("c%0d_rdy", c), mem_resp_ready_and_o, pat[c]);
      chk($sformatf("c%0d_v", c), mem_resp_v_o, 2'b10);
      if (mem_resp_v_o[1] && mem_resp_ready_and_i[1])
        rx_q.push_back(mem_resp_data_o[DW +: DW]);
      if (pat[c]) b++;
    end
    chk("c_rx_cnt", rx_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < rx_q.size()) chk($sformatf("c_rx%0d", k), rx_q[k], rsp_of(k));
    end
    void'(exp_q.pop_front());
    @(negedge clk_i);
    drive_resp(1'b0, 1'b0, 2'b11, 0);
    #2;
    chk("c_empty_rdy", mem_resp_ready_and_o, 0);

    // Ch0 4-beat burst locks out ch1, including a stalled beat.
    begin
      logic rdy_s [5];
      int   bt_s  [5];
      rdy_s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      bt_s  = '{0, 1, 2, 2, 3};
      for (int c = 0; c < 5; c++) begin
        @(negedge clk_i);
        drive_cmd(2'b11, {1'b1, bt_s[c] == 3}, rdy_s[c], bt_s[c], 0);
        #2;
        chk($sformatf("d%0d_v", c), mem_cmd_v_o, 1);
        chk($sformatf("d%0d_rdy", c), mem_cmd_ready_and_o, rdy_s[c] ? 2'b01 : 2'b00);
        chk($sformatf("d%0d_hdr", c), mem_cmd_header_o, hdr_of(0, bt_s[c]));
        chk($sformatf("d%0d_dat", c), mem_cmd_data_o, dat_of(0, bt_s[c]));
        chk($sformatf("d%0d_last", c), mem_cmd_last_o, bt_s[c] == 3);
        if (c == 0) exp_q.push_back(0);
      end
    end
    @(negedge clk_i);
    drive_cmd(2'b10, 2'b10, 1'b1, 0, 0);
    #2;
    chk("d_ch1_rdy", mem_cmd_ready_and_o, 2'b10);
    chk("d_ch1_hdr", mem_cmd_header_o, hdr_of(1, 0));
    exp_q.push_back(1);
    drain(2);

    // Reset in the middle of a ch0 burst after the pointer moved to ch1.
    @(negedge clk_i);
    drive_cmd(2'b01, 2'b00, 1'b1, 0, 0);
    #2;
    chk("e_beat0_rdy", mem_cmd_ready_and_o, 2'b01);
    @(negedge clk_i);
    drive_cmd(2'b11, 2'b10, 1'b1, 1, 0);
    #2;
    chk("e_lock_rdy", mem_cmd_ready_and_o, 2'b01);
    @(negedge clk_i);
    reset_i = 1'b1;
    #2;
    chk("e_rst_v", mem_cmd_v_o, 0);
    chk("e_rst_rdy", mem_cmd_ready_and_o, 0);
    exp_q.delete();
    @(negedge clk_i);
    reset_i = 1'b0;
    drive_cmd(2'b11, 2'b11, 1'b0, 5, 5);
    #2;
    chk("e_post_v", mem_cmd_v_o, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      drive_cmd(2'b11, 2'b11, 1'b0, 5, 5);
      #2;
      if (c == 0) begin
        chk("e_stall_v", mem_cmd_v_o, 1);
        chk("e_stall_rdy", mem_cmd_ready_and_o, 0);
        chk("e_grant_ch0", mem_cmd_header_o, hdr_of(0, 5));
        chk("e_trk_empty", mem_resp_ready_and_o, 0);
      end
    end
    @(negedge clk_i);
    drive_cmd(2'b11, 2'b11, 1'b1, 5, 5);
    #2;
    chk("stall_count", stall_count_o, EXP_STALL);
    chk("e_accept_rdy", mem_cmd_ready_and_o, 2'b01);
    exp_q.push_back(0);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
